alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue stage directly upstream of `alu`. It accepts decoded instruction fields and register-file read data from decode, and translates opcode/funct3/funct7[5] into the 4-bit `alu_op`. It selects `in_b` between rs2 data and the immediate, and presents `alu_op`/`in_a`/`in_b` to the ALU from a single-entry valid/ready pipeline register with stall and flush.

## Interface
- `XLEN`, 32, operand/immediate width
- `CNT_W`, 32, width of the issued-instruction counter

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  kill held and incoming instruction (synchronous)
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `opcode`  in  7  instruction[6:0]
- `funct3`  in  3  instruction[14:12]
- `funct7_5`  in  1  instruction[30]
- `rs1_data`  in  XLEN  register source 1 value
- `rs2_data`  in  XLEN  register source 2 value
- `imm`  in  XLEN  sign-extended immediate from decode
- `out_valid`  out  1  ALU inputs valid
- `out_ready`  in  1  downstream consumes this cycle
- `alu_op`  out  4  to `alu.alu_op`
- `in_a`  out  XLEN  to `alu.in_a`
- `in_b`  out  XLEN  to `alu.in_b`
- `illegal`  out  1  held instruction has no supported ALU mapping
- `issue_count`  out  CNT_W  completed output handshakes

## Operation
- Op encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, INVALID 1111.
- R-type 0110011, `in_b`=rs2:
  - f3 000 with f7_5=0 → ADD; with f7_5=1 → SUB.
  - f3 111/f7_5=0 → AND; f3 110/f7_5=0 → OR.
  - Anything else → illegal.
- I-type 0010011, `in_b`=imm, f7_5 ignored: f3 000 → ADD, 111 → AND, 110 → OR. Anything else → illegal.
- Load 0000011 / store 0100011: ADD, `in_b`=imm, funct fields ignored.
- Branch 1100011: f3 000 (beq) or 001 (bne) → SUB, `in_b`=rs2. Other f3 → illegal.
- Any other opcode → illegal.
- Illegal instructions still issue, with `alu_op`=1111, `illegal`=1, `in_a`=rs1, `in_b`=rs2, so downstream can trap. This stage does not drop them.
- `in_a` is always rs1_data.
- `issue_count` increments by 1 on each `out_valid && out_ready` and wraps modulo 2^CNT_W.

## Timing
- Reset values: `out_valid`=0, `alu_op`=0000, `in_a`=`in_b`=0, `illegal`=0, `issue_count`=0.
- During reset, `in_ready`=0.
- `in_ready = !rst && !flush && (!out_valid || out_ready)`. This path is combinational from `out_ready`.
- Capture on a rising edge when `in_valid && in_ready`. Latency is 1 cycle to `out_valid`=1.
- Back-to-back: when `out_ready`=1 and `in_valid`=1, the new instruction replaces the old one on the same edge. Throughput is 1/cycle.
- Stall: while `out_valid && !out_ready`, `alu_op`, `in_a`, `in_b` and `illegal` hold stable, and `in_ready`=0.
- `out_valid` never drops without a handshake, except on flush or reset.
- Flush has priority over everything except reset:
  - next cycle `out_valid`=0;
  - no capture that cycle;
  - the payload registers may hold stale data.
- Flush does not affect `issue_count`, except that a handshake completing in the flush cycle still counts.
- Reset mid-stall discards the held instruction; the counter does not increment.
- Payload registers load only on capture (no enable-free toggling). The decode is purely combinational ahead of the register.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_INVALID;
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - funct3 constants.
- `alu` also uses this package.
- Sub-module `alu_op_decode`: combinational; (opcode, funct3, funct7_5) → (`alu_op`, `use_imm`, `illegal`).
- Top: handshake, payload register, counter.

## Test plan
- Reset: assert `rst` 2 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `alu_op`=0000, `in_a`=`in_b`=0, `issue_count`=0.
- SUB issue: opcode 0110011, f3 000, f7_5=1, rs1=0x10, rs2=0x3 → next cycle `out_valid`=1, `alu_op`=0110, `in_a`=0x10, `in_b`=0x3; ALU result 0xD, zero=0.
- addi: opcode 0010011, f3 000, rs1=0x1, rs2=0x55, imm=0xFFFFFFFF → `alu_op`=0010, `in_b`=0xFFFFFFFF; ALU result 0, zero=1.
- Backpressure: one instruction held, `out_ready`=0 for 3 cycles, new `in_valid`=1 held → `in_ready`=0 and payload stable for 3 cycles, count unchanged; on `out_ready`=1 → count+1 and the new instruction appears next cycle.
- Flush: `out_valid`=1, `in_valid`=1, `flush`=1 for 1 cycle → next cycle `out_valid`=0, count unchanged; the next `in_valid` issues normally.
- Illegal: opcode 0110111 (LUI), then 0010011 f3 100 (xori) → each issues with `alu_op`=1111, `illegal`=1; an adjacent legal OR (f3 110) shows `illegal`=0, `alu_op`=0001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, opcode/funct3 constants and
// the control payload carried by the issue stage.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_INVALID = 4'b1111
  } alu_op_t;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_OR      = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_AND     = 3'b111;
  localparam logic [FUNCT3_W-1:0] F3_BEQ     = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE     = 3'b001;

  // Control part of an issued instruction, held alongside the operands.
  typedef struct packed {
    alu_op_t alu_op;
    logic    illegal;
  } issue_ctl_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-ALU issue bus.
//   master: decode/consumer side (drives instruction fields and out_ready)
//   slave : issue stage (drives in_ready, ALU operands, status, counter)
interface alu_issue_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  imm;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic             illegal;
  logic [CNT_W-1:0] issue_count;

  modport master (
    output in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, out_ready,
    input  in_ready, out_valid, alu_op, in_a, in_b, illegal, issue_count
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data, imm, out_ready,
    output in_ready, out_valid, alu_op, in_a, in_b, illegal, issue_count
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU operation,
// operand-B select and illegal flag.
//   opcode, funct3, funct7_5 : instruction fields
//   alu_op                   : ALU operation (ALU_INVALID when illegal)
//   use_imm                  : 1 selects the immediate as operand B
//   illegal                  : no supported ALU mapping
import alu_pkg::*;

module alu_op_decode (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                funct7_5,
  output alu_op_t             alu_op,
  output logic                use_imm,
  output logic                illegal
);

  // Illegal by default: trapping instructions keep rs2 as operand B.
  always_comb begin
    alu_op  = ALU_INVALID;
    use_imm = 1'b0;
    illegal = 1'b1;
    case (opcode)
      OP_R: begin
        case (funct3)
          F3_ADD_SUB: begin
            alu_op  = funct7_5 ? ALU_SUB : ALU_ADD;
            illegal = 1'b0;
          end
          F3_AND: if (!funct7_5) begin
            alu_op  = ALU_AND;
            illegal = 1'b0;
          end
          F3_OR: if (!funct7_5) begin
            alu_op  = ALU_OR;
            illegal = 1'b0;
          end
          default: ;
        endcase
      end
      OP_I: begin
        case (funct3)
          F3_ADD_SUB: begin
            alu_op  = ALU_ADD;
            use_imm = 1'b1;
            illegal = 1'b0;
          end
          F3_AND: begin
            alu_op  = ALU_AND;
            use_imm = 1'b1;
            illegal = 1'b0;
          end
          F3_OR: begin
            alu_op  = ALU_OR;
            use_imm = 1'b1;
            illegal = 1'b0;
          end
          default: ;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        illegal = 1'b0;
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          alu_op  = ALU_SUB;
          illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage feeding the ALU: decodes the instruction, selects
// operand B, and holds alu_op/in_a/in_b in a single-entry valid/ready
// register with stall and flush. Counts completed output handshakes.
//   clk, rst : clock, synchronous active-high reset
//   flush    : kills the held and the incoming instruction
//   bus      : decode inputs, ALU outputs, handshakes, issue_count
import alu_pkg::*;

module alu_issue_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  alu_issue_stage_if.slave bus
);

  alu_op_t          dec_op;
  logic             dec_use_imm;
  logic             dec_illegal;
  logic             in_ready_c;
  logic             capture_c;
  logic             handshake_c;

  logic             valid_q;
  issue_ctl_t       ctl_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [CNT_W-1:0] cnt_q;

  alu_op_decode u_decode (
    .opcode   (bus.opcode),
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .alu_op   (dec_op),
    .use_imm  (dec_use_imm),
    .illegal  (dec_illegal)
  );

  // Ready is combinational from out_ready so a drained slot refills same edge.
  assign in_ready_c  = !rst && !flush && (!valid_q || bus.out_ready);
  assign capture_c   = bus.in_valid && in_ready_c;
  assign handshake_c = valid_q && bus.out_ready;

  // Pipeline register, handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctl_q   <= '{alu_op: ALU_AND, illegal: 1'b0};
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      if (handshake_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flush) begin
        valid_q <= 1'b0;
      end else if (capture_c) begin
        valid_q <= 1'b1;
      end else if (handshake_c) begin
        valid_q <= 1'b0;
      end
      if (capture_c) begin
        ctl_q <= '{alu_op: dec_op, illegal: dec_illegal};
        a_q   <= bus.rs1_data;
        b_q   <= dec_use_imm ? bus.imm : bus.rs2_data;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = valid_q;
  assign bus.alu_op      = ctl_q.alu_op;
  assign bus.illegal     = ctl_q.illegal;
  assign bus.in_a        = a_q;
  assign bus.in_b        = b_q;
  assign bus.issue_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios with literal
// expectations, then random traffic compared against a transaction model.
module tb_alu_issue_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model state: the one instruction the stage should be holding.
  bit          m_valid = 1'b0;
  logic [3:0]  m_op    = 4'h0;
  logic [31:0] m_a     = '0;
  logic [31:0] m_b     = '0;
  bit          m_ill   = 1'b0;
  logic [31:0] m_cnt   = '0;
  bit          m_zero  = 1'b1;  // payload known to be reset zeros

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Instruction semantics as a lookup: returns operation, operand-B choice, illegal.
  function automatic void ref_decode(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                     output logic [3:0] op, output logic ub, output logic il);
    op = 4'b1111; ub = 1'b0; il = 1'b1;
    if (opc == 7'b0110011) begin
      if (f3 == 3'd0)             begin op = f7 ? 4'b0110 : 4'b0010; il = 1'b0; end
      else if (f3 == 3'd7 && !f7) begin op = 4'b0000; il = 1'b0; end
      else if (f3 == 3'd6 && !f7) begin op = 4'b0001; il = 1'b0; end
    end else if (opc == 7'b0010011) begin
      if (f3 == 3'd0)      begin op = 4'b0010; ub = 1'b1; il = 1'b0; end
      else if (f3 == 3'd7) begin op = 4'b0000; ub = 1'b1; il = 1'b0; end
      else if (f3 == 3'd6) begin op = 4'b0001; ub = 1'b1; il = 1'b0; end
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      op = 4'b0010; ub = 1'b1; il = 1'b0;
    end else if (opc == 7'b1100011) begin
      if (f3 == 3'd0 || f3 == 3'd1) begin op = 4'b0110; il = 1'b0; end
    end
  endfunction

  // Advance the model on every rising edge from the inputs the bench drove.
  always @(posedge clk) begin : model_upd
    logic [3:0] op;
    logic ub, il;
    bit rdy, hs;
    if (rst) begin
      m_valid = 1'b0; m_op = 4'h0; m_a = '0; m_b = '0; m_ill = 1'b0;
      m_cnt = '0; m_zero = 1'b1;
    end else begin
      rdy = !flush && (!m_valid || bus.out_ready);
      hs  = m_valid && bus.out_ready;
      if (hs) m_cnt = m_cnt + 32'd1;
      if (flush) begin
        m_valid = 1'b0;
      end else if (bus.in_valid && rdy) begin
        ref_decode(bus.opcode, bus.funct3, bus.funct7_5, op, ub, il);
        m_valid = 1'b1;
        m_op    = op;
        m_ill   = il;
        m_a     = bus.rs1_data;
        m_b     = ub ? bus.imm : bus.rs2_data;
        m_zero  = 1'b0;
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin : compare
    bit exp_rdy;
    exp_rdy = !rst && !flush && (!m_valid || bus.out_ready);
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("issue_count", 64'(bus.issue_count), 64'(m_cnt));
    if (m_valid || m_zero) begin
      check("alu_op", 64'(bus.alu_op), 64'(m_op));
      check("in_a", 64'(bus.in_a), 64'(m_a));
      check("in_b", 64'(bus.in_b), 64'(m_b));
      check("illegal", 64'(bus.illegal), 64'(m_ill));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    bus.in_valid = v;
    bus.opcode   = opc;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    bus.imm      = im;
  endtask

  initial begin : stim
    logic [31:0] res;
    logic [6:0]  opc;
    bus.out_ready = 1'b1;
    drive(1'b1, 7'b0110011, 3'd0, 1'b0, 32'h5, 32'h6, 32'h7);

    // Reset held two cycles with in_valid high.
    step(); step();
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_alu_op", 64'(bus.alu_op), 64'd0);
    check("rst_in_a", 64'(bus.in_a), 64'd0);
    check("rst_in_b", 64'(bus.in_b), 64'd0);
    check("rst_count", 64'(bus.issue_count), 64'd0);

    // SUB issue.
    @(posedge clk); #2;
    rst = 1'b0;
    drive(1'b1, 7'b0110011, 3'd0, 1'b1, 32'h10, 32'h3, 32'h99);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("sub_valid", 64'(bus.out_valid), 64'd1);
    check("sub_op", 64'(bus.alu_op), 64'h6);
    check("sub_a", 64'(bus.in_a), 64'h10);
    check("sub_b", 64'(bus.in_b), 64'h3);
    res = bus.in_a - bus.in_b;
    check("sub_result", 64'(res), 64'hD);

    // addi with all-ones immediate.
    step();
    drive(1'b1, 7'b0010011, 3'd0, 1'b0, 32'h1, 32'h55, 32'hFFFF_FFFF);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("addi_op", 64'(bus.alu_op), 64'h2);
    check("addi_b", 64'(bus.in_b), 64'hFFFF_FFFF);
    res = bus.in_a + bus.in_b;
    check("addi_zero", 64'(res == 32'd0), 64'd1);
    check("addi_count", 64'(bus.issue_count), 64'd1);

    // Backpressure: OR held three cycles while an AND waits.
    step();
    bus.out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'd6, 1'b0, 32'hA, 32'hB, 32'h0);
    step();
    drive(1'b1, 7'b0110011, 3'd7, 1'b0, 32'hC, 32'hD, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", 64'(bus.in_ready), 64'd0);
      check("stall_op", 64'(bus.alu_op), 64'h1);
      check("stall_a", 64'(bus.in_a), 64'hA);
      check("stall_b", 64'(bus.in_b), 64'hB);
      check("stall_count", 64'(bus.issue_count), 64'd2);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("unstall_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("next_op", 64'(bus.alu_op), 64'h0);
    check("next_a", 64'(bus.in_a), 64'hC);
    check("next_count", 64'(bus.issue_count), 64'd3);

    // Flush with a held instruction and a new one offered.
    step();
    flush = 1'b1;
    drive(1'b1, 7'b0110011, 3'd0, 1'b0, 32'h7, 32'h8, 32'h0);
    step();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_count", 64'(bus.issue_count), 64'd3);
    step();
    drive(1'b1, 7'b0110111, 3'd0, 1'b0, 32'h11, 32'h12, 32'h13);  // LUI next
    @(negedge clk);
    check("post_flush_valid", 64'(bus.out_valid), 64'd1);
    check("post_flush_op", 64'(bus.alu_op), 64'h2);
    check("post_flush_b", 64'(bus.in_b), 64'h8);

    // Illegal instructions issue back to back, followed by a legal ori.
    step();
    drive(1'b1, 7'b0010011, 3'd4, 1'b0, 32'h21, 32'h22, 32'h23);  // xori
    @(negedge clk);
    check("lui_op", 64'(bus.alu_op), 64'hF);
    check("lui_ill", 64'(bus.illegal), 64'd1);
    check("lui_b", 64'(bus.in_b), 64'h12);
    step();
    drive(1'b1, 7'b0010011, 3'd6, 1'b0, 32'h31, 32'h32, 32'h33);  // ori
    @(negedge clk);
    check("xori_op", 64'(bus.alu_op), 64'hF);
    check("xori_ill", 64'(bus.illegal), 64'd1);
    check("xori_a", 64'(bus.in_a), 64'h21);
    check("xori_b", 64'(bus.in_b), 64'h22);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("ori_op", 64'(bus.alu_op), 64'h1);
    check("ori_ill", 64'(bus.illegal), 64'd0);
    check("ori_b", 64'(bus.in_b), 64'h33);
    check("ori_count", 64'(bus.issue_count), 64'd6);

    // Random traffic against the model.
    repeat (3000) begin
      step();
      rst           = ($urandom_range(0, 63) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 6))
        0: opc = 7'b0110011;
        1: opc = 7'b0010011;
        2: opc = 7'b0000011;
        3: opc = 7'b0100011;
        4: opc = 7'b1100011;
        5: opc = 7'b0110111;
        default: opc = 7'($urandom);
      endcase
      drive(1'($urandom_range(0, 9) < 7), opc, 3'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom);
    end
    step();
    rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
